// File: rtl/systolic_seq_ctrl.sv
// Sequencer for one NxN matrix multiply on a PE mesh: captures operands, clears
// the accumulators, streams A rows / B columns, then latches the mesh results.
// Define SYSTOLIC_SEQ_SKEW_EN for a registered-forwarding mesh with a skewed feed
// of 3N-2 steps; leave it undefined for a combinational mesh with an N-step feed.
module systolic_seq_ctrl #(
    parameter int N  = 4,
    parameter int DW = 8
) (
    input  logic                  i_clk,
    input  logic                  i_arst,
    input  logic                  i_start,
    input  logic                  i_abort,
    input  logic [N*N*DW-1:0]     i_a,
    input  logic [N*N*DW-1:0]     i_b,
    input  logic [N*N*2*DW-1:0]   i_y,
    output logic [N*DW-1:0]       o_row_a,
    output logic [N*DW-1:0]       o_col_b,
    output logic                  o_clr,
    output logic                  o_busy,
    output logic                  o_done,
    output logic [N*N*2*DW-1:0]   o_c
);

`ifdef SYSTOLIC_SEQ_SKEW_EN
    localparam int F = 3 * N - 2;
`else
    localparam int F = N;
`endif
    localparam int KW = $clog2(3 * N);
    localparam logic [KW-1:0] K_LAST = KW'(F - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CLEAR = 3'd1,
        S_FEED  = 3'd2,
        S_DRAIN = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t                 state_q, state_d;
    logic [KW-1:0]          k_q, k_d;
    logic [N*N*DW-1:0]      a_q, a_d, b_q, b_d;
    logic [N*DW-1:0]        row_a_q, row_a_d, col_b_q, col_b_d;
    logic                   clr_q, clr_d, busy_q, busy_d, done_q, done_d;
    logic [N*N*2*DW-1:0]    c_q, c_d;
    int                     k_int_s;

    assign k_int_s = int'(k_d);

    // State, step counter and captured operands.
    always_ff @(posedge i_clk or posedge i_arst) begin
        if (i_arst) begin
            state_q <= S_IDLE;
            k_q     <= '0;
            a_q     <= '0;
            b_q     <= '0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            a_q     <= a_d;
            b_q     <= b_d;
        end
    end

    // Next-state, step counter and operand capture; abort outranks every normal transition.
    always_comb begin
        state_d = state_q;
        if (i_abort && (state_q != S_IDLE)) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (i_start) begin
                        state_d = S_CLEAR;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
                S_CLEAR: state_d = S_FEED;
                S_FEED: begin
                    if (k_q == K_LAST) begin
                        state_d = S_DRAIN;
                    end else begin
                        state_d = S_FEED;
                    end
                end
                S_DRAIN: state_d = S_DONE;
                S_DONE:  state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end

        if ((state_q == S_FEED) && (state_d == S_FEED)) begin
            k_d = k_q + KW'(1);
        end else begin
            k_d = '0;
        end

        if ((state_q == S_IDLE) && i_start) begin
            a_d = i_a;
            b_d = i_b;
        end else begin
            a_d = a_q;
            b_d = b_q;
        end
    end

    // Output values for the upcoming state, so every output leaves a flop.
    always_comb begin
        clr_d   = (state_d == S_CLEAR);
        busy_d  = (state_d != S_IDLE);
        done_d  = (state_d == S_DONE);
        row_a_d = '0;
        col_b_d = '0;

        if (state_d == S_DONE) begin
            c_d = i_y;
        end else begin
            c_d = c_q;
        end

        if (state_d == S_FEED) begin
            for (int r = 0; r < N; r++) begin
`ifdef SYSTOLIC_SEQ_SKEW_EN
                if ((k_int_s >= r) && ((k_int_s - r) < N)) begin
                    row_a_d[r*DW +: DW] = a_q[(r*N + k_int_s - r)*DW +: DW];
                end else begin
                    row_a_d[r*DW +: DW] = '0;
                end
                if ((k_int_s >= r) && ((k_int_s - r) < N)) begin
                    col_b_d[r*DW +: DW] = b_q[((k_int_s - r)*N + r)*DW +: DW];
                end else begin
                    col_b_d[r*DW +: DW] = '0;
                end
`else
                if (k_int_s < N) begin
                    row_a_d[r*DW +: DW] = a_q[(r*N + k_int_s)*DW +: DW];
                    col_b_d[r*DW +: DW] = b_q[(k_int_s*N + r)*DW +: DW];
                end else begin
                    row_a_d[r*DW +: DW] = '0;
                    col_b_d[r*DW +: DW] = '0;
                end
`endif
            end
        end else begin
            row_a_d = '0;
            col_b_d = '0;
        end
    end

    // Output registers.
    always_ff @(posedge i_clk or posedge i_arst) begin
        if (i_arst) begin
            row_a_q <= '0;
            col_b_q <= '0;
            clr_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            c_q     <= '0;
        end else begin
            row_a_q <= row_a_d;
            col_b_q <= col_b_d;
            clr_q   <= clr_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            c_q     <= c_d;
        end
    end

    assign o_row_a = row_a_q;
    assign o_col_b = col_b_q;
    assign o_clr   = clr_q;
    assign o_busy  = busy_q;
    assign o_done  = done_q;
    assign o_c     = c_q;

endmodule
